// File: rtl/adc_spi_cmd_seq.sv
// Command sequencer for the ADC SPI write engine: buffers words in a FIFO, issues
// each as a one-cycle strobe, waits for done, enforces a CS-high gap, and watchdogs.
module adc_spi_cmd_seq #(
    parameter int WIDTH          = 16,
    parameter int DEPTH          = 8,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [WIDTH-1:0]           s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [WIDTH-1:0]           spi_data,
    output logic                       spi_en,
    input  logic                       spi_done,
    input  logic                       err_clr,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam state_t POST_WAIT = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] spi_data_q, spi_data_d;
    logic             spi_en_q, spi_en_d;
    logic [WW-1:0]    wd_q, wd_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             timeout_err_q, timeout_err_d;
    logic             push, pop, err_set;

    // Valid/ready: a word transfers on any edge where s_valid && s_ready are both high;
    // s_ready depends only on the registered level, never on s_valid.
    assign s_ready = (level_q != FULL_LEVEL);
    assign push    = s_valid && s_ready;

    always_ff @(posedge aclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        spi_en_d   = 1'b0;
        spi_data_d = spi_data_q;
        wd_d       = wd_q;
        gap_d      = gap_q;
        err_set    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (level_q != '0) begin
                    pop        = 1'b1;
                    spi_en_d   = 1'b1;
                    spi_data_d = mem_q[rd_ptr_q];
                    wd_d       = '0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                wd_d = wd_q + WW'(1);
                // Done on the expiry cycle still counts as a clean completion.
                if (spi_done) begin
                    gap_d   = '0;
                    state_d = POST_WAIT;
                end else if (wd_q == WD_LAST) begin
                    err_set = 1'b1;
                    gap_d   = '0;
                    state_d = POST_WAIT;
                end
            end
            ST_GAP: begin
                gap_d = gap_q + GW'(1);
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (err_set) begin
            timeout_err_d = 1'b1;
        end else if (err_clr) begin
            timeout_err_d = 1'b0;
        end else begin
            timeout_err_d = timeout_err_q;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            spi_data_q    <= '0;
            spi_en_q      <= 1'b0;
            wd_q          <= '0;
            gap_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            spi_data_q    <= spi_data_d;
            spi_en_q      <= spi_en_d;
            wd_q          <= wd_d;
            gap_q         <= gap_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign busy        = (state_q != ST_IDLE) || (level_q != '0);
    assign level       = level_q;
    assign spi_data    = spi_data_q;
    assign spi_en      = spi_en_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_adc_spi_cmd_seq.sv
// Directed bench for adc_spi_cmd_seq: single word, back-to-back, full FIFO,
// watchdog timeout, done/timeout race and asynchronous reset mid-transfer.
module tb_adc_spi_cmd_seq;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH + 1);
    localparam int XFER  = 129;

    logic             aclk;
    logic             areset;
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] spi_data;
    logic             spi_en;
    logic             spi_done;
    logic             err_clr;
    logic             busy;
    logic [LW-1:0]    level;
    logic             timeout_err;

    logic done_auto;
    logic done_man;
    logic auto_done;
    int   done_cnt;
    int   cyc;
    int   n_checks;
    int   n_bad;

    logic [WIDTH-1:0] en_dat_q[$];
    int               en_cyc_q[$];

    assign spi_done = done_auto | done_man;

    adc_spi_cmd_seq #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .GAP_CYCLES(4),
        .TIMEOUT_CYCLES(256)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .spi_data(spi_data),
        .spi_en(spi_en),
        .spi_done(spi_done),
        .err_clr(err_clr),
        .busy(busy),
        .level(level),
        .timeout_err(timeout_err)
    );

    // clock and cycle index (cycle k is the interval after the k-th rising edge)
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // spi_en monitor
    always @(negedge aclk) begin
        if (spi_en) begin
            en_dat_q.push_back(spi_data);
            en_cyc_q.push_back(cyc);
        end
    end

    // write-engine model: done XFER cycles after each spi_en when enabled
    initial begin
        done_auto = 1'b0;
        done_cnt  = 0;
        forever begin
            @(posedge aclk);
            #1;
            done_auto = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) done_auto = 1'b1;
            end
            @(negedge aclk);
            if (auto_done && spi_en) done_cnt = XFER;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got sim time %0t required finish earlier", $time);
        $fatal(1, "bench time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic wait_en(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge aclk);
            if (spi_en) seen = 1'b1;
        end
        check("en_seen", 32'(seen), 32'd1);
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        s_data  = w;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
    endtask

    int c0, d, e, e2, n, qs;

    initial begin
        n_checks  = 0;
        n_bad     = 0;
        areset    = 1'b1;
        s_data    = '0;
        s_valid   = 1'b0;
        err_clr   = 1'b0;
        done_man  = 1'b0;
        auto_done = 1'b0;

        // reset state
        repeat (3) tick();
        check("rst_level", 32'(level), 32'd0);
        check("rst_en", 32'(spi_en), 32'd0);
        check("rst_data", 32'(spi_data), 32'd0);
        check("rst_err", 32'(timeout_err), 32'd0);
        check("rst_ready", 32'(s_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        areset = 1'b0;
        repeat (2) tick();

        // single word
        auto_done = 1'b1;
        c0 = cyc;
        push_word(16'hA5C3);
        @(negedge aclk);
        check("t1_level1", 32'(level), 32'd1);
        check("t1_no_en_yet", 32'(spi_en), 32'd0);
        wait_en(10);
        check("t1_en_cycle", 32'(cyc), 32'(c0 + 2));
        check("t1_data", 32'(spi_data), 32'hA5C3);
        check("t1_level0", 32'(level), 32'd0);
        wait_to(c0 + 2 + 133);
        @(negedge aclk);
        check("t1_busy_gap_end", 32'(busy), 32'd1);
        tick();
        @(negedge aclk);
        check("t1_busy_low", 32'(busy), 32'd0);
        check("t1_data_held", 32'(spi_data), 32'hA5C3);
        tick();

        // back-to-back
        en_dat_q.delete();
        en_cyc_q.delete();
        c0 = cyc;
        s_valid = 1'b1;
        s_data = 16'h0001; tick();
        s_data = 16'h0002; tick();
        s_data = 16'h0003; tick();
        s_valid = 1'b0;
        wait_to(c0 + 410);
        check("t2_count", 32'(en_dat_q.size()), 32'd3);
        check("t2_first_cycle", 32'(en_cyc_q[0]), 32'(c0 + 2));
        for (int i = 0; i < 3; i++) begin
            check("t2_order", 32'(en_dat_q[i]), 32'(i + 1));
        end
        for (int i = 1; i < 3; i++) begin
            check("t2_spacing", 32'(en_cyc_q[i] - en_cyc_q[i-1]), 32'd135);
        end
        @(negedge aclk);
        check("t2_idle", 32'(busy), 32'd0);
        tick();

        // full FIFO
        auto_done = 1'b0;
        en_dat_q.delete();
        en_cyc_q.delete();
        n = 0;
        for (int i = 0; i < 14; i++) begin
            s_data  = 16'(16'h0100 + n);
            s_valid = 1'b1;
            @(negedge aclk);
            if (s_ready) n++;
            tick();
        end
        s_valid = 1'b0;
        check("t3_accepted", 32'(n), 32'd9);
        check("t3_level_full", 32'(level), 32'd8);
        check("t3_ready_low", 32'(s_ready), 32'd0);
        check("t3_one_issue", 32'(en_dat_q.size()), 32'd1);
        check("t3_first_word", 32'(en_dat_q[0]), 32'h0100);
        d = cyc;
        done_man  = 1'b1;
        auto_done = 1'b1;
        tick();
        done_man = 1'b0;
        wait_to(d + 5);
        @(negedge aclk);
        check("t3_ready_before_pop", 32'(s_ready), 32'd0);
        check("t3_no_en_in_gap", 32'(spi_en), 32'd0);
        tick();
        @(negedge aclk);
        check("t3_next_en", 32'(spi_en), 32'd1);
        check("t3_next_data", 32'(spi_data), 32'h0101);
        check("t3_ready_after_pop", 32'(s_ready), 32'd1);
        check("t3_level7", 32'(level), 32'd7);
        wait_to(d + 6 + 7 * 135 + 140);
        check("t3_total", 32'(en_dat_q.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            check("t3_word", 32'(en_dat_q[i]), 32'(16'h0100 + i));
        end
        @(negedge aclk);
        check("t3_drained", 32'(busy), 32'd0);
        tick();

        // watchdog timeout with a second word queued
        auto_done = 1'b0;
        s_valid = 1'b1;
        s_data = 16'h1234; tick();
        s_data = 16'h5678; tick();
        s_valid = 1'b0;
        wait_en(10);
        e = cyc;
        check("t4_data", 32'(spi_data), 32'h1234);
        wait_to(e + 255);
        @(negedge aclk);
        check("t4_err_before", 32'(timeout_err), 32'd0);
        tick();
        @(negedge aclk);
        check("t4_err_set", 32'(timeout_err), 32'd1);
        check("t4_busy_gap", 32'(busy), 32'd1);
        wait_to(e + 261);
        @(negedge aclk);
        check("t4_next_en", 32'(spi_en), 32'd1);
        check("t4_next_data", 32'(spi_data), 32'h5678);
        e2 = cyc;
        tick();
        err_clr = 1'b1;
        @(negedge aclk);
        check("t4_err_held", 32'(timeout_err), 32'd1);
        tick();
        err_clr = 1'b0;
        @(negedge aclk);
        check("t4_err_cleared", 32'(timeout_err), 32'd0);
        wait_to(e2 + 255);
        err_clr = 1'b1;
        @(negedge aclk);
        check("t4_err_pre_race", 32'(timeout_err), 32'd0);
        tick();
        err_clr = 1'b0;
        @(negedge aclk);
        check("t4_set_wins", 32'(timeout_err), 32'd1);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge aclk);
        check("t4_err_clear2", 32'(timeout_err), 32'd0);
        wait_to(e2 + 270);

        // done on the expiry cycle
        push_word(16'hBEEF);
        wait_en(10);
        e = cyc;
        wait_to(e + 255);
        done_man = 1'b1;
        @(negedge aclk);
        check("t5_err_before", 32'(timeout_err), 32'd0);
        tick();
        done_man = 1'b0;
        @(negedge aclk);
        check("t5_no_err", 32'(timeout_err), 32'd0);
        check("t5_busy_gap", 32'(busy), 32'd1);
        wait_to(e + 262);
        @(negedge aclk);
        check("t5_idle", 32'(busy), 32'd0);
        check("t5_no_err_late", 32'(timeout_err), 32'd0);
        tick();

        // asynchronous reset with three words queued
        en_dat_q.delete();
        en_cyc_q.delete();
        s_valid = 1'b1;
        s_data = 16'hC001; tick();
        s_data = 16'hC002; tick();
        s_data = 16'hC003; tick();
        s_data = 16'hC004; tick();
        s_valid = 1'b0;
        @(negedge aclk);
        check("t6_level3", 32'(level), 32'd3);
        #3;
        areset = 1'b1;
        #1;
        check("t6_rst_level", 32'(level), 32'd0);
        check("t6_rst_en", 32'(spi_en), 32'd0);
        check("t6_rst_ready", 32'(s_ready), 32'd1);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_data", 32'(spi_data), 32'd0);
        repeat (2) tick();
        areset = 1'b0;
        qs = en_dat_q.size();
        repeat (20) tick();
        check("t6_no_en_after", 32'(en_dat_q.size()), 32'(qs));
        check("t6_level_stays0", 32'(level), 32'd0);
        c0 = cyc;
        push_word(16'hD00D);
        wait_en(10);
        check("t6_new_en_cycle", 32'(cyc), 32'(c0 + 2));
        check("t6_new_data", 32'(spi_data), 32'hD00D);
        tick();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
